// File: rtl/punc_datapath_mc.sv
// Multicycle PUnC datapath: PC, IR, register file and NZP driven by
// controller micro-commands (valid/ready) with a variable-latency memory.
// Ports: clk/rst; cmd_* command port; done/br_taken retire status;
// mem_* req/ready memory port; pc/ir/nzp state; rf_debug_* debug read.
// Optional PUNC_DP_PERF_EN adds perf_retired / perf_stall counters.
module punc_datapath_mc #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int RF_DEPTH = 8,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  localparam int RA_W = $clog2(RF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [RA_W-1:0]   cmd_dst,
  input  logic [RA_W-1:0]   cmd_src0,
  input  logic [RA_W-1:0]   cmd_src1,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic [2:0]        cmd_cc,
  output logic              done,
  output logic              br_taken,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [2:0]        nzp,
`ifdef PUNC_DP_PERF_EN
  output logic [31:0]       perf_retired,
  output logic [31:0]       perf_stall,
`endif
  input  logic [RA_W-1:0]   rf_debug_addr,
  output logic [DATA_W-1:0] rf_debug_data
);

  typedef enum logic [3:0] {
    OP_ADD, OP_AND, OP_NOT, OP_ADDI,
    OP_ANDI, OP_LEA, OP_LD, OP_LDR,
    OP_LDI, OP_ST, OP_STR, OP_STI,
    OP_BR, OP_JMP, OP_JSR, OP_FETCH
  } op_t;

  typedef enum logic [1:0] {
    IDLE, MEM_A, MEM_B
  } state_t;

  localparam logic [RA_W-1:0] LINK = RA_W'(7);

  state_t state_q, state_d;
  logic req_q, req_d, fin;
  op_t op, op_q;
  logic [RA_W-1:0] dst_q;
  logic [DATA_W-1:0] s1v_q, addr_q;
  logic done_q, brt_q;
  logic [DATA_W-1:0] rf [RF_DEPTH];
  logic [DATA_W-1:0] s0, s1, alu, maddr;
  logic acc, is_mem, rdy_edge, take;

  function automatic logic [2:0] cc_of(
    input logic [DATA_W-1:0] v
  );
    if (v == '0) return 3'b010;
    if (v[DATA_W-1]) return 3'b100;
    return 3'b001;
  endfunction

  assign op = op_t'(cmd_op);
  assign s0 = rf[cmd_src0];
  assign s1 = rf[cmd_src1];
  assign cmd_ready = (state_q == IDLE);
  assign acc = cmd_valid && cmd_ready;
  assign is_mem = op inside {OP_LD, OP_LDR,
    OP_LDI, OP_ST, OP_STR, OP_STI, OP_FETCH};
  assign rdy_edge = req_q && mem_ready;
  assign take = |(cmd_cc & nzp);

  assign done = done_q;
  assign br_taken = brt_q;
  assign mem_req = req_q;
  assign mem_addr = addr_q[ADDR_W-1:0];
  assign mem_wdata = s1v_q;
  assign rf_debug_data = rf[rf_debug_addr];

  assign mem_we = req_q && (
    (state_q == MEM_A &&
      (op_q == OP_ST || op_q == OP_STR)) ||
    (state_q == MEM_B && op_q == OP_STI));

  always_comb begin
    alu = '0;
    unique case (op)
      OP_ADD:  alu = s0 + s1;
      OP_AND:  alu = s0 & s1;
      OP_NOT:  alu = ~s0;
      OP_ADDI: alu = s0 + cmd_imm;
      OP_ANDI: alu = s0 & cmd_imm;
      OP_LEA:  alu = pc + cmd_imm;
      default: alu = '0;
    endcase
  end

  always_comb begin
    maddr = pc + cmd_imm;
    unique case (op)
      OP_LDR, OP_STR: maddr = s0 + cmd_imm;
      OP_FETCH:       maddr = pc;
      default:        maddr = pc + cmd_imm;
    endcase
  end

  // Indirect ops leave MEM_A with req low, so MEM_B spends one
  // cycle idle on the bus before raising the second request.
  always_comb begin
    state_d = state_q;
    req_d = req_q;
    fin = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc && is_mem) begin
          state_d = MEM_A;
          req_d = 1'b1;
        end else if (acc) begin
          fin = 1'b1;
        end
      end
      MEM_A: begin
        if (rdy_edge) begin
          req_d = 1'b0;
          if (op_q == OP_LDI || op_q == OP_STI) begin
            state_d = MEM_B;
          end else begin
            state_d = IDLE;
            fin = 1'b1;
          end
        end
      end
      MEM_B: begin
        if (!req_q) begin
          req_d = 1'b1;
        end else if (mem_ready) begin
          req_d = 1'b0;
          state_d = IDLE;
          fin = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      ir <= '0;
      nzp <= 3'b010;
      op_q <= OP_ADD;
      dst_q <= '0;
      s1v_q <= '0;
      addr_q <= '0;
      done_q <= 1'b0;
      brt_q <= 1'b0;
      for (int i = 0; i < RF_DEPTH; i++) begin
        rf[i] <= '0;
      end
    end else begin
      done_q <= fin;
      brt_q <= 1'b0;
      if (acc) begin
        op_q <= op;
        dst_q <= cmd_dst;
        s1v_q <= s1;
        addr_q <= maddr;
        unique case (op)
          OP_ADD, OP_AND, OP_NOT,
          OP_ADDI, OP_ANDI, OP_LEA: begin
            rf[cmd_dst] <= alu;
            nzp <= cc_of(alu);
          end
          OP_BR: begin
            brt_q <= take;
            if (take) pc <= pc + cmd_imm;
          end
          OP_JMP: pc <= s0;
          OP_JSR: begin
            rf[LINK] <= pc;
            pc <= (cmd_imm != '0) ? pc + cmd_imm : s0;
          end
          default: ;
        endcase
      end
      if (rdy_edge) begin
        if (state_q == MEM_A) begin
          unique case (op_q)
            OP_LD, OP_LDR: begin
              rf[dst_q] <= mem_rdata;
              nzp <= cc_of(mem_rdata);
            end
            OP_FETCH: begin
              ir <= mem_rdata;
              pc <= pc + 1'b1;
            end
            OP_LDI, OP_STI: addr_q <= mem_rdata;
            default: ;
          endcase
        end else if (op_q == OP_LDI) begin
          rf[dst_q] <= mem_rdata;
          nzp <= cc_of(mem_rdata);
        end
      end
    end
  end

`ifdef PUNC_DP_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_retired <= '0;
      perf_stall <= '0;
    end else begin
      if (done_q && perf_retired != '1)
        perf_retired <= perf_retired + 1'b1;
      if (req_q && !mem_ready && perf_stall != '1)
        perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: doc/punc_datapath_mc.md
Name: punc_datapath_mc

Overview:
- Parametrised, multicycle successor to the PUnC LC3 datapath.
- Executes one micro-command at a time from the PUnC controller over a valid/ready command port. Holds PC, IR, the register file and the NZP condition codes.
- Memory is reached through a variable-latency req/ready port, so wait-state memories can be attached.
- Width, register count and reset PC are generic.

Parameters:
- DATA_W, 16: datapath/register width. Arithmetic is modulo 2^DATA_W.
- ADDR_W, 16: memory address width. Must satisfy ADDR_W <= DATA_W. Addresses are the low ADDR_W bits of the computed value.
- RF_DEPTH, 8: number of registers, power of 2 and >= 8. RA_W = log2(RF_DEPTH).
- RESET_PC, 0: PC value after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  controller command valid.
- cmd_ready  out  1  datapath can accept a command.
- cmd_op  in  4  0 ADD, 1 AND, 2 NOT, 3 ADDI, 4 ANDI, 5 LEA, 6 LD, 7 LDR, 8 LDI, 9 ST, 10 STR, 11 STI, 12 BR, 13 JMP, 14 JSR, 15 FETCH.
- cmd_dst  in  RA_W  destination register.
- cmd_src0  in  RA_W  source/base register.
- cmd_src1  in  RA_W  second source / store-data register.
- cmd_imm  in  DATA_W  immediate or offset, already sign-extended by the controller.
- cmd_cc  in  3  BR condition mask {n,z,p}.
- done  out  1  one-cycle pulse: command retired.
- br_taken  out  1  valid while done is high for BR; 1 when the branch was taken.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  store data.
- mem_ready  in  1  request completes this edge; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_W  load data.
- pc  out  DATA_W  current PC.
- ir  out  DATA_W  instruction register.
- nzp  out  3  condition codes.
- rf_debug_addr  in  RA_W  debug read address.
- rf_debug_data  out  DATA_W  combinational read of the register at rf_debug_addr.

Behaviour:
- Reset values (asynchronous, effective immediately):
  - pc=RESET_PC, ir=0, all registers 0, nzp=3'b010.
  - State IDLE, mem_req=0, mem_we=0, done=0, br_taken=0.
  - A reset that arrives mid-command aborts the command: mem_req drops immediately and nothing is written back.
- States: IDLE, MEM_A, MEM_B. cmd_ready=1 only in IDLE.
- A command is accepted at an edge where cmd_valid && cmd_ready. At acceptance the datapath latches the op, dst, imm, cc, and the values of src0/src1 read at that edge. cmd_valid while busy is ignored.
- Register/control ops (ADD..LEA, BR, JMP, JSR) commit at the accept edge and stay in IDLE. done is high the next cycle, so back-to-back throughput is 1 command per cycle.
  - ADD/AND/NOT/ADDI/ANDI/LEA write dst. LEA computes pc+imm.
  - BR: pc <= pc+imm if (cmd_cc & nzp) != 0, else pc is unchanged.
  - JMP: pc <= src0.
  - JSR: register 7 <= pc and pc <= pc+imm when imm != 0 (LC3 JSR). When imm == 0, pc <= src0 (JSRR). The target uses the pre-write src0 value, so JSRR R7 jumps to the old R7.
- Memory ops: the accept edge moves the state to MEM_A. From the next cycle, mem_req=1 with a stable address/data until the edge where mem_ready=1.
  - Addresses: LD/ST/LDI/STI use pc+imm; LDR/STR use src0+imm; FETCH uses pc.
  - LD/LDR: dst <= mem_rdata at the ready edge, then IDLE.
  - ST/STR: write src1 to the address, then IDLE.
  - FETCH: ir <= mem_rdata and pc <= pc+1 (wraps) at the ready edge.
  - LDI/STI: the MEM_A read returns the pointer. MEM_B then issues the second access to that pointer (a read into dst, or a write of src1).
  - mem_req is deasserted the cycle after the ready edge, before any second access. done pulses the cycle after the final ready edge.
- NZP updates on every register-file write except the JSR link:
  - 3'b010 if the written value == 0.
  - 3'b100 if its MSB is set.
  - 3'b001 otherwise.
- A register write and a read of the same register in the same cycle return the old value (no bypass).
- PC arithmetic wraps modulo 2^DATA_W. Address truncation to ADDR_W is silent.

Optional Feature:
- PUNC_DP_PERF_EN: adds outputs perf_retired[31:0] and perf_stall[31:0], both reset to 0.
  - perf_retired increments on each done.
  - perf_stall increments each cycle with mem_req && !mem_ready.
  - Both saturate at 2^32-1.
- Without the macro these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then apply ADDI dst=1 src0=0 imm=5, then ADD dst=2 src0=1 src1=1 back-to-back. Required: R1=5, R2=10, done high on two consecutive cycles, nzp=3'b001.
- ADDI R3 = R0 + 16'hFFFF, then BR cc=3'b100 imm=4 at pc=16'h0010. Required: nzp=3'b100, pc=16'h0014, br_taken=1; repeating with cc=3'b001 leaves pc unchanged and br_taken=0.
- FETCH at pc=16'h0000 with 3 wait cycles and mem_rdata=16'h1234. Required: mem_req high for 4 cycles with stable addr 0, ir=16'h1234, pc=1, done a single pulse, perf_stall=3 when PUNC_DP_PERF_EN is defined.
- LDI imm=2 at pc=16'h0020, memory holding mem[16'h0022]=16'h0100 and mem[16'h0100]=16'h0000. Required: two requests to addresses 16'h0022 then 16'h0100, mem_req low between them, dst=0, nzp=3'b010.
- JSRR with src0=7, R7=16'h0040, pc=16'h0005. Required: pc=16'h0040, R7=16'h0005, nzp unchanged.
- STR mid-wait with rst asserted while mem_req=1. Required: mem_req drops immediately, pc=RESET_PC, no write completes, cmd_ready=1 after rst is released.
